// File: rtl/xbar_bank_dispatch_pkg.sv
// Shared HTU field widths and the bank FIFO payload layout for the bank dispatcher.
package xbar_bank_dispatch_pkg;

  localparam int unsigned OPCODE_W = 2;
  localparam int unsigned ADDR_W   = 28;  // line address, byte address bits [31:4]
  localparam int unsigned WBUF_W   = 8;
  localparam int unsigned ADDR_LSB = 4;   // byte-address bit that line-address bit 0 maps to

  // Payload packing order, MSB first: opcode, addr, wbuffer_id (ch_id is kept alongside).
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   addr;
    logic [WBUF_W-1:0]   wbuffer_id;
  } htu_req_t;

endpackage

// File: rtl/xbar_bank_dispatch_if.sv
// Channel-side and bank-side HTU buses of the bank dispatcher.
// XBAR_DISPATCH_PERF_EN adds the per-bank stall counter bus.
interface xbar_bank_dispatch_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned CH_ID_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]           ch_htu_valid_i;
  logic [NUM_CH-1:0]           ch_htu_ready_o;
  logic [2*NUM_CH-1:0]         ch_htu_opcode_i;
  logic [28*NUM_CH-1:0]        ch_htu_addr_i;
  logic [8*NUM_CH-1:0]         ch_htu_wbuffer_id_i;

  logic [NUM_BANKS-1:0]         bank_htu_valid_o;
  logic [NUM_BANKS-1:0]         bank_htu_ready_i;
  logic [CH_ID_W*NUM_BANKS-1:0] bank_htu_ch_id_o;
  logic [2*NUM_BANKS-1:0]       bank_htu_opcode_o;
  logic [28*NUM_BANKS-1:0]      bank_htu_addr_o;
  logic [8*NUM_BANKS-1:0]       bank_htu_wbuffer_id_o;
`ifdef XBAR_DISPATCH_PERF_EN
  logic [16*NUM_BANKS-1:0]      bank_stall_cnt_o;
`endif

  modport slave (
    input  ch_htu_valid_i, ch_htu_opcode_i, ch_htu_addr_i, ch_htu_wbuffer_id_i,
    output ch_htu_ready_o,
    input  bank_htu_ready_i,
    output bank_htu_valid_o, bank_htu_ch_id_o, bank_htu_opcode_o, bank_htu_addr_o,
    output bank_htu_wbuffer_id_o
`ifdef XBAR_DISPATCH_PERF_EN
    , output bank_stall_cnt_o
`endif
  );

  modport master (
    output ch_htu_valid_i, ch_htu_opcode_i, ch_htu_addr_i, ch_htu_wbuffer_id_i,
    input  ch_htu_ready_o,
    output bank_htu_ready_i,
    input  bank_htu_valid_o, bank_htu_ch_id_o, bank_htu_opcode_o, bank_htu_addr_o,
    input  bank_htu_wbuffer_id_o
`ifdef XBAR_DISPATCH_PERF_EN
    , input bank_stall_cnt_o
`endif
  );

endinterface

// File: rtl/xbar_rr_arb.sv
// Round-robin arbiter for one bank: one-hot grant, pointer moves past the winner on a taken grant.
module xbar_rr_arb #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              en_i,
  input  logic              taken_i,
  output logic [NUM_CH-1:0] gnt_o
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    // Scan starting at the pointer so the channel after the last winner goes first.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(ptr_q) + i) % NUM_CH;
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    if (taken_i) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (gnt_o[k]) ptr_d = IdxW'((k + 1) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xbar_bank_dispatch.sv
// Channel-to-bank HTU dispatcher: bank decode, per-bank round-robin, per-bank FIFO.
// Defining XBAR_DISPATCH_PERF_EN adds saturating 16-bit per-bank stall counters.
module xbar_bank_dispatch
  import xbar_bank_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CH_ID_W    = $clog2(NUM_CH)
) (
  input logic               clk_i,
  input logic               rst_i,
  xbar_bank_dispatch_if.slave bus
);

  localparam int unsigned BankW = $clog2(NUM_BANKS);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  logic [NUM_CH-1:0] req_bank [NUM_BANKS];
  logic [NUM_CH-1:0] gnt_bank [NUM_BANKS];

  // Each channel requests only the bank picked by its low line-address bits.
  always_comb begin
    logic [BankW-1:0] sel;
    sel = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) req_bank[b] = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sel = bus.ch_htu_addr_i[ADDR_W*c +: BankW];
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        req_bank[b][c] = bus.ch_htu_valid_i[c] && (sel == BankW'(b));
      end
    end
  end

  always_comb begin
    bus.ch_htu_ready_o = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) bus.ch_htu_ready_o |= gnt_bank[b];
    if (rst_i) bus.ch_htu_ready_o = '0;
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [CntW-1:0]    count_q;
    logic [PtrW-1:0]    wptr_q, rptr_q;
    logic [CH_ID_W-1:0] mem_ch_q  [FIFO_DEPTH];
    htu_req_t           mem_req_q [FIFO_DEPTH];
    logic [CH_ID_W-1:0] push_ch;
    htu_req_t           push_req;
    htu_req_t           head_req;
    logic               full, push, pop, valid;

    // Fullness uses the registered count, so a pop in the same cycle does not open a slot.
    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign valid = (count_q != '0);
    assign push  = |gnt_bank[g];
    assign pop   = valid && bus.bank_htu_ready_i[g];

    xbar_rr_arb #(
      .NUM_CH (NUM_CH)
    ) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_bank[g]),
      .en_i    (!full && !rst_i),
      .taken_i (push),
      .gnt_o   (gnt_bank[g])
    );

    always_comb begin
      push_ch  = '0;
      push_req = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (gnt_bank[g][c]) begin
          push_ch             = CH_ID_W'(c);
          push_req.opcode     = bus.ch_htu_opcode_i[OPCODE_W*c +: OPCODE_W];
          push_req.addr       = bus.ch_htu_addr_i[ADDR_W*c +: ADDR_W];
          push_req.wbuffer_id = bus.ch_htu_wbuffer_id_i[WBUF_W*c +: WBUF_W];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        count_q <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem_ch_q[wptr_q]  <= push_ch;
        mem_req_q[wptr_q] <= push_req;
      end
    end

    assign head_req = mem_req_q[rptr_q];

    assign bus.bank_htu_valid_o[g]                            = valid;
    assign bus.bank_htu_ch_id_o[CH_ID_W*g +: CH_ID_W]         = mem_ch_q[rptr_q];
    assign bus.bank_htu_opcode_o[OPCODE_W*g +: OPCODE_W]      = head_req.opcode;
    assign bus.bank_htu_addr_o[ADDR_W*g +: ADDR_W]            = head_req.addr;
    assign bus.bank_htu_wbuffer_id_o[WBUF_W*g +: WBUF_W]      = head_req.wbuffer_id;

`ifdef XBAR_DISPATCH_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stall_q <= '0;
      end else if (valid && !bus.bank_htu_ready_i[g] && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end

    assign bus.bank_stall_cnt_o[16*g +: 16] = stall_q;
`endif
  end

endmodule

// File: tb/tb_xbar_bank_dispatch.sv
// Directed self-checking bench for xbar_bank_dispatch with default parameters.
module tb_xbar_bank_dispatch;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned NUM_BANKS  = 4;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CH_ID_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  xbar_bank_dispatch_if #(
    .NUM_CH    (NUM_CH),
    .NUM_BANKS (NUM_BANKS),
    .CH_ID_W   (CH_ID_W)
  ) bus ();

  xbar_bank_dispatch #(
    .NUM_CH     (NUM_CH),
    .NUM_BANKS  (NUM_BANKS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CH_ID_W    (CH_ID_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] addr_of(input int c, input int bank);
    return {12'h5A0, 12'(c), 4'(bank)};
  endfunction

  task automatic req(input int c, input int bank, input logic [1:0] op, input logic [7:0] wb);
    bus.ch_htu_valid_i[c]             = 1'b1;
    bus.ch_htu_opcode_i[2*c +: 2]     = op;
    bus.ch_htu_addr_i[28*c +: 28]     = addr_of(c, bank);
    bus.ch_htu_wbuffer_id_i[8*c +: 8] = wb;
  endtask

  task automatic drop(input int c);
    bus.ch_htu_valid_i[c] = 1'b0;
  endtask

  function automatic logic [1:0] out_ch(input int b);
    return bus.bank_htu_ch_id_o[CH_ID_W*b +: CH_ID_W];
  endfunction

  int exp_g[5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.ch_htu_valid_i      = '0;
    bus.ch_htu_opcode_i     = '0;
    bus.ch_htu_addr_i       = '0;
    bus.ch_htu_wbuffer_id_i = '0;
    bus.bank_htu_ready_i    = '1;

    // Reset: ready held low even with requests pending
    tick();
    req(0, 0, 2'b01, 8'h11);
    #1;
    check("rst_ready", 64'(bus.ch_htu_ready_o), 64'h0);
    tick();
    bus.ch_htu_valid_i = '0;
    rst = 1'b0;
    #1;
    check("rst_bank_valid", 64'(bus.bank_htu_valid_o), 64'h0);

    // Single request: ch1 -> bank 2 (byte addr 0x20)
    tick();
    req(1, 2, 2'b10, 8'hA5);
    bus.ch_htu_addr_i[28*1 +: 28] = 28'h0000002;
    #1;
    check("single_ready", 64'(bus.ch_htu_ready_o), 64'b0010);
    check("single_no_bypass", 64'(bus.bank_htu_valid_o), 64'h0);
    tick();
    drop(1);
    #1;
    check("single_valid", 64'(bus.bank_htu_valid_o), 64'b0100);
    check("single_ch_id", 64'(out_ch(2)), 64'd1);
    check("single_opcode", 64'(bus.bank_htu_opcode_o[4 +: 2]), 64'b10);
    check("single_wbuf", 64'(bus.bank_htu_wbuffer_id_o[16 +: 8]), 64'hA5);
    check("single_addr", 64'(bus.bank_htu_addr_o[56 +: 28]), 64'h0000002);
    tick();
    check("single_drained", 64'(bus.bank_htu_valid_o), 64'h0);

    // Contention: all channels on bank 1, grants rotate 0,1,2,3,0
    for (int c = 0; c < 4; c++) req(c, 1, 2'(c), 8'(8'h40 + c));
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_grant%0d", i), 64'(bus.ch_htu_ready_o), 64'(1 << exp_g[i]));
      if (i > 0) check($sformatf("rr_out%0d", i), 64'(out_ch(1)), 64'(exp_g[i-1]));
      tick();
    end
    bus.ch_htu_valid_i = '0;
    #1;
    check("rr_out_last", 64'(out_ch(1)), 64'd0);
    tick();
    check("rr_drained", 64'(bus.bank_htu_valid_o), 64'h0);

    // Parallel banks: ch0 -> bank 0, ch3 -> bank 3
    req(0, 0, 2'b11, 8'h01);
    req(3, 3, 2'b01, 8'h03);
    #1;
    check("par_ready", 64'(bus.ch_htu_ready_o), 64'b1001);
    tick();
    bus.ch_htu_valid_i = '0;
    #1;
    check("par_valid", 64'(bus.bank_htu_valid_o), 64'b1001);
    check("par_ch0", 64'(out_ch(0)), 64'd0);
    check("par_ch3", 64'(out_ch(3)), 64'd3);
    tick();

    // Full FIFO on bank 0; its pointer sits at 1 after the ch0 grant above
    bus.bank_htu_ready_i[0] = 1'b0;
    req(0, 0, 2'b00, 8'hB0);
    req(1, 0, 2'b01, 8'hB1);
    req(2, 0, 2'b10, 8'hB2);
    #1;
    check("full_g1", 64'(bus.ch_htu_ready_o), 64'b0010);
    tick();
    drop(1);
    #1;
    check("full_g2", 64'(bus.ch_htu_ready_o), 64'b0100);
    tick();
    drop(2);
    #1;
    check("full_stall", 64'(bus.ch_htu_ready_o), 64'b0000);
    check("full_head", 64'(out_ch(0)), 64'd1);
    tick();
    bus.bank_htu_ready_i[0] = 1'b1;
    #1;
    check("full_pop_no_free", 64'(bus.ch_htu_ready_o), 64'b0000);
    tick();
    check("full_ready_back", 64'(bus.ch_htu_ready_o), 64'b0001);
    check("full_order2", 64'(out_ch(0)), 64'd2);
    tick();
    drop(0);
    #1;
    check("full_order3", 64'(out_ch(0)), 64'd0);
    check("full_order3_wb", 64'(bus.bank_htu_wbuffer_id_o[0 +: 8]), 64'hB0);
    tick();
    check("full_drained", 64'(bus.bank_htu_valid_o), 64'h0);

    // Reset mid-flight: two entries buffered in bank 1 (pointer at 1)
    bus.bank_htu_ready_i[1] = 1'b0;
    req(2, 1, 2'b00, 8'hC2);
    req(3, 1, 2'b00, 8'hC3);
    #1;
    check("rst_mid_g1", 64'(bus.ch_htu_ready_o), 64'b0100);
    tick();
    drop(2);
    #1;
    check("rst_mid_g2", 64'(bus.ch_htu_ready_o), 64'b1000);
    tick();
    drop(3);
    #1;
    check("rst_mid_buffered", 64'(bus.bank_htu_valid_o), 64'b0010);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) req(c, 1, 2'b11, 8'(8'hD0 + c));
    #1;
    check("rst_mid_ready", 64'(bus.ch_htu_ready_o), 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_flushed", 64'(bus.bank_htu_valid_o), 64'h0);
    check("rst_mid_restart", 64'(bus.ch_htu_ready_o), 64'b0001);
    tick();
    drop(0);
    #1;
    check("rst_mid_out", 64'(out_ch(1)), 64'd0);
    check("rst_mid_next", 64'(bus.ch_htu_ready_o), 64'b0010);
    bus.ch_htu_valid_i   = '0;
    bus.bank_htu_ready_i = '1;
    tick();
    tick();
    tick();
    check("final_empty", 64'(bus.bank_htu_valid_o), 64'h0);

`ifdef XBAR_DISPATCH_PERF_EN
    // Stall counter on bank 2: 5 stalled cycles, then saturation
    check("perf_reset", 64'(bus.bank_stall_cnt_o[32 +: 16]), 64'h0);
    bus.bank_htu_ready_i[2] = 1'b0;
    req(0, 2, 2'b01, 8'hE0);
    tick();
    drop(0);
    repeat (5) tick();
    check("perf_count5", 64'(bus.bank_stall_cnt_o[32 +: 16]), 64'd5);
    repeat (65540) tick();
    check("perf_saturate", 64'(bus.bank_stall_cnt_o[32 +: 16]), 64'hFFFF);
    bus.bank_htu_ready_i[2] = 1'b1;
    tick();
    check("perf_hold", 64'(bus.bank_stall_cnt_o[32 +: 16]), 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
